lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: req_valid  in  1  CPU access request; req_ready  out  1  request accepted when both high at posedge.
REQ-004 SHALL have ports: req_we  in  1  1=store, 0=load; req_size  in  2  01 byte, 10 halfword, 11 word, 00 illegal; req_unsigned  in  1  zero-extend loads.
REQ-005 SHALL have ports: req_addr  in  32  byte address; req_wdata  in  32  store data, LSB-aligned.
REQ-006 SHALL have ports: resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  32  extended load data; resp_err  out  1  access rejected.
REQ-007 SHALL have memory-side ports: MemAddr  out  32; dataIn  out  32; MemWrite  out  2; MemRead  out  2; Unsigned  out  1; dataOut  in  32.
REQ-008 SHALL use MemRead/MemWrite encoding 00 none, 01 byte, 10 halfword, 11 word.
REQ-009 SHALL treat the data memory as 512 bytes, combinational read, write committed on the falling edge of clk.

Function
REQ-010 SHALL implement FSM states IDLE, ACCESS, DONE; req_ready=1 only in IDLE.
REQ-011 SHALL, on accept in IDLE, register addr, size, we, unsigned, wdata and go to ACCESS, or to DONE with error latched when REQ-012 applies.
REQ-012 SHALL flag error when req_size=00, or req_addr+bytes-1 > 511, or the access is misaligned (REQ-023).
REQ-013 SHALL, in ACCESS, drive MemAddr=latched addr, MemRead=size for loads, MemWrite=size for stores, dataIn=latched wdata, Unsigned=latched unsigned.
REQ-014 SHALL drive MemRead=00, MemWrite=00, MemAddr=0, dataIn=0, Unsigned=0 in every cycle not in ACCESS, and on every error path.
REQ-015 SHALL capture dataOut at the posedge ending the last ACCESS cycle and transition to DONE.
REQ-016 SHALL, in DONE, assert resp_valid for exactly one cycle, present resp_rdata and resp_err, then return to IDLE.
REQ-017 SHALL present resp_rdata=0 for stores and errors; loads zero- or sign-extended per latched unsigned.
REQ-018 SHALL give aligned-access latency: accept at edge N, ACCESS during cycle N+1, resp_valid during cycle N+2; errors: resp_valid during cycle N+1.
REQ-019 SHALL ignore req_valid outside IDLE; back-to-back throughput one access per 3 cycles.
REQ-020 SHALL hold resp_rdata and resp_err stable from DONE until the next DONE.

Reset
REQ-021 SHALL, on rst high, immediately enter IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, all memory-side outputs 0.
REQ-022 SHALL abort any in-flight access on rst without a response; byte writes already committed by a split store remain in memory.

Configuration
REQ-023 SHALL define misalignment as halfword with addr[0]=1 or word with addr[1:0]!=00.
REQ-024 SHALL, with LSU_MISALIGN_SPLIT_EN defined, execute misaligned accesses as consecutive ACCESS cycles of byte accesses (2 for halfword, 4 for word) at addr, addr+1, ..., low byte first.
REQ-025 SHALL, in split mode, use MemRead=01 with Unsigned=1 per byte, assemble bytes little-endian, apply extension once at the end, and drive dataIn[7:0] with the matching store byte.
REQ-026 SHALL, with LSU_MISALIGN_SPLIT_EN defined, give split latency: resp_valid during cycle N+1+bytes.
REQ-027 SHALL, without LSU_MISALIGN_SPLIT_EN, reject misaligned accesses via the error path of REQ-011.

Verification
REQ-028 SHALL pass: store word 0x8899AABB to addr 0x10, then load halfword signed at 0x12 -> resp_rdata=0xFFFF8899, resp_err=0.
REQ-029 SHALL pass: load byte unsigned at 0x13 after REQ-028 -> resp_rdata=0x00000088; signed -> 0xFFFFFF88.
REQ-030 SHALL pass: load word at 0x1FE -> resp_err=1, resp_rdata=0, no MemRead/MemWrite pulse, resp_valid one cycle after accept.
REQ-031 SHALL pass: store word 0x11223344 at 0x21 -> without macro resp_err=1 and memory unchanged; with macro four byte writes, then load word at 0x21 -> 0x11223344.
REQ-032 SHALL pass: assert rst during ACCESS of a store -> outputs reset at once, no resp_valid, next request accepted normally.
REQ-033 SHALL pass: hold req_valid high across three requests -> req_ready low in ACCESS/DONE, exactly three resp_valid pulses at 3-cycle spacing.

Source files
------------

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a CPU request port and a
// 512-byte data memory. Each accepted request runs IDLE -> ACCESS -> DONE,
// or IDLE -> DONE when the access is rejected.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When defined, misaligned
// halfword/word accesses run as consecutive byte accesses. When undefined,
// they are rejected.
module lsu_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] MemAddr,
    output logic [31:0] dataIn,
    output logic [1:0]  MemWrite,
    output logic [1:0]  MemRead,
    output logic        Unsigned,
    input  logic [31:0] dataOut
);

    localparam int unsigned MEM_BYTES = 512;
    localparam int unsigned AW        = 32;
    localparam int unsigned DW        = 32;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [AW-1:0]   lat_addr;
    logic [DW-1:0]   lat_wdata;
    logic [1:0]      lat_size;
    logic            lat_we;
    logic            lat_uns;
    logic            lat_split;
    logic [1:0]      lat_last;
    logic [1:0]      idx;
    logic [DW-1:0]   asm_data;

    logic [2:0]      req_bytes;
    logic [AW:0]     req_end;
    logic            req_misaligned;
    logic            req_bad;

    logic [DW-1:0]   merged;
    logic [DW-1:0]   raw;
    logic [DW-1:0]   ext;

    // Request decode: byte count, range and alignment checks
    always_comb begin
        req_bytes = 3'd0;
        case (req_size)
            2'b01:   req_bytes = 3'd1;
            2'b10:   req_bytes = 3'd2;
            2'b11:   req_bytes = 3'd4;
            default: req_bytes = 3'd0;
        endcase
        req_end        = {1'b0, req_addr} + (AW+1)'(req_bytes) - (AW+1)'(1);
        req_misaligned = ((req_size == 2'b10) && req_addr[0]) ||
                         ((req_size == 2'b11) && (req_addr[1:0] != 2'b00));
        req_bad        = (req_size == 2'b00) ||
                         (req_end > (AW+1)'(MEM_BYTES - 1)) ||
                         (req_misaligned && !SPLIT_EN);
    end

    // Load data: merge the current byte in split mode, then extend once
    always_comb begin
        merged = asm_data;
        merged[{idx, 3'b000} +: 8] = dataOut[7:0];
        raw = lat_split ? merged : dataOut;
        case (lat_size)
            2'b01:   ext = lat_uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b10:   ext = lat_uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: ext = raw;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = req_bad ? DONE : ACCESS;
            ACCESS:  if (idx == lat_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode: memory bus is only driven while in ACCESS
    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        MemAddr    = '0;
        dataIn     = '0;
        MemWrite   = 2'b00;
        MemRead    = 2'b00;
        Unsigned   = 1'b0;
        case (state)
            IDLE:   req_ready = 1'b1;
            ACCESS: begin
                if (lat_split) begin
                    MemAddr  = lat_addr + AW'(idx);
                    dataIn   = {24'd0, lat_wdata[{idx, 3'b000} +: 8]};
                    Unsigned = 1'b1;
                    if (lat_we) MemWrite = 2'b01;
                    else        MemRead  = 2'b01;
                end else begin
                    MemAddr  = lat_addr;
                    dataIn   = lat_wdata;
                    Unsigned = lat_uns;
                    if (lat_we) MemWrite = lat_size;
                    else        MemRead  = lat_size;
                end
            end
            DONE:    resp_valid = 1'b1;
            default: ;
        endcase
    end

    // Request latch, byte sequencing and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_size   <= 2'b00;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_split  <= 1'b0;
            lat_last   <= 2'd0;
            idx        <= 2'd0;
            asm_data   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_size  <= req_size;
                        lat_we    <= req_we;
                        lat_uns   <= req_unsigned;
                        lat_split <= SPLIT_EN && req_misaligned;
                        lat_last  <= (SPLIT_EN && req_misaligned) ? 2'(req_bytes - 3'd1) : 2'd0;
                        idx       <= 2'd0;
                        asm_data  <= '0;
                        if (req_bad) begin
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    asm_data <= merged;
                    idx      <= idx + 2'd1;
                    if (idx == lat_last) begin
                        resp_rdata <= lat_we ? '0 : ext;
                        resp_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a 512-byte memory model
// and a byte-array reference model. Honours LSU_MISALIGN_SPLIT_EN.
`timescale 1ns/1ps
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] MemAddr;
    logic [31:0] dataIn;
    logic [1:0]  MemWrite;
    logic [1:0]  MemRead;
    logic        Unsigned;
    logic [31:0] dataOut;

    lsu_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .MemAddr(MemAddr), .dataIn(dataIn), .MemWrite(MemWrite), .MemRead(MemRead),
        .Unsigned(Unsigned), .dataOut(dataOut)
    );

    always #5 clk = ~clk;

`ifdef LSU_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int accept_cyc = 0;
    logic preload;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_byte(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    // Data memory: combinational read, writes on the falling edge
    logic [7:0] mem [0:511];
    logic [8:0] ma0, ma1, ma2, ma3;
    assign ma0 = MemAddr[8:0];
    assign ma1 = ma0 + 9'd1;
    assign ma2 = ma0 + 9'd2;
    assign ma3 = ma0 + 9'd3;

    always @(negedge clk) begin
        if (preload) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_byte(i);
        end else begin
            case (MemWrite)
                2'b01: mem[ma0] <= dataIn[7:0];
                2'b10: begin mem[ma0] <= dataIn[7:0]; mem[ma1] <= dataIn[15:8]; end
                2'b11: begin
                    mem[ma0] <= dataIn[7:0];   mem[ma1] <= dataIn[15:8];
                    mem[ma2] <= dataIn[23:16]; mem[ma3] <= dataIn[31:24];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        case (MemRead)
            2'b01:   dataOut = Unsigned ? {24'd0, mem[ma0]} : {{24{mem[ma0][7]}}, mem[ma0]};
            2'b10:   dataOut = Unsigned ? {16'd0, mem[ma1], mem[ma0]}
                                        : {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
            2'b11:   dataOut = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
            default: dataOut = 32'd0;
        endcase
    end

    // Reference memory contents as the CPU should see them
    logic [7:0] ref_mem [0:511];

    // Monitor: idle-bus checks, access counting and scoreboard compare
    always @(negedge clk) begin
        if (!rst && !preload) begin
            if (MemRead != 2'b00 || MemWrite != 2'b00) begin
                acc_cnt++;
            end else begin
                checks++;
                if (MemAddr != 32'd0 || dataIn != 32'd0 || Unsigned != 1'b0) begin
                    errors++;
                    $display("FAIL idle_bus: got addr=%h din=%h uns=%0d need all zero", MemAddr, dataIn, Unsigned);
                end
            end
            if (resp_valid) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: got resp_valid=1 at cyc %0d need no response", cyc);
                end else begin
                    me = sb.pop_front();
                    if (resp_rdata !== me.rdata || resp_err !== me.err || cyc != me.cyc || acc_cnt != me.acc) begin
                        errors++;
                        $display("FAIL %s: got rdata=%h err=%0d cyc=%0d acc=%0d need rdata=%h err=%0d cyc=%0d acc=%0d",
                                 me.name, resp_rdata, resp_err, cyc, acc_cnt, me.rdata, me.err, me.cyc, me.acc);
                    end
                end
                acc_cnt = 0;
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h need %h", name, got, want);
        end
    endtask

    // Present a request, wait for acceptance, push the modelled response.
    // Called at a falling edge; returns one falling edge after acceptance.
    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, input string name);
        exp_t e;
        int nb;
        logic [63:0] last;
        bit mis;
        bit err;
        logic [31:0] v;
        int waited;
        req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata;
        waited = 0;
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (!req_ready) begin
            errors++;
            $display("FAIL %s_accept: got req_ready=0 need 1 within 20 cycles", name);
            req_valid = 1'b0;
            return;
        end
        nb   = (size == 2'd1) ? 1 : (size == 2'd2) ? 2 : (size == 2'd3) ? 4 : 0;
        last = {32'd0, addr} + 64'(nb) - 64'd1;
        mis  = (size == 2'd2 && addr[0]) || (size == 2'd3 && addr[1:0] != 2'b00);
        err  = (nb == 0) || (last > 64'd511) || (mis && !SPLIT);
        v = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < nb; i++) ref_mem[int'(addr[8:0]) + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < nb; i++) v[8*i +: 8] = ref_mem[int'(addr[8:0]) + i];
                if (!uns && nb < 4 && v[8*nb-1])
                    for (int b = 8*nb; b < 32; b++) v[b] = 1'b1;
            end
        end
        accept_cyc = cyc + 1;
        e.rdata = (we || err) ? 32'd0 : v;
        e.err   = err;
        e.cyc   = err ? accept_cyc : (mis ? accept_cyc + nb : accept_cyc + 1);
        e.acc   = err ? 0 : (mis ? nb : 1);
        e.name  = name;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        req_valid = 1'b0;
        repeat (k) @(negedge clk);
    endtask

    task automatic drain(input string name);
        req_valid = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pending need 0", name, sb.size());
            sb.delete();
        end
    endtask

    int n1, n2, n3;
    int bad_bytes;
    logic [31:0] ra;
    int r;

    initial begin
        rst = 1'b1; preload = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        for (int i = 0; i < 512; i++) ref_mem[i] = init_byte(i);
        @(negedge clk); @(negedge clk);
        #1;
        check_val("reset_ready", {31'd0, req_ready}, 32'd1);
        check_val("reset_valid", {31'd0, resp_valid}, 32'd0);
        check_val("reset_rdata", resp_rdata, 32'd0);
        check_val("reset_err", {31'd0, resp_err}, 32'd0);
        check_val("reset_bus", {27'd0, MemRead, MemWrite, Unsigned}, 32'd0);
        check_val("reset_addr", MemAddr | dataIn, 32'd0);
        preload = 1'b0;
        rst = 1'b0;
        @(negedge clk);

        // Store word then signed halfword load from its upper half
        issue(1'b1, 2'b11, 1'b0, 32'h10, 32'h8899AABB, "st_w_10");
        idle(1);
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'd0, "ld_h_s_12");
        drain("ld_h_s_12");
        check_val("ld_h_s_12_const", resp_rdata, 32'hFFFF8899);
        check_val("ld_h_s_12_err", {31'd0, resp_err}, 32'd0);

        // Byte loads, unsigned and signed
        issue(1'b0, 2'b01, 1'b1, 32'h13, 32'd0, "ld_b_u_13");
        drain("ld_b_u_13");
        check_val("ld_b_u_13_const", resp_rdata, 32'h00000088);
        issue(1'b0, 2'b01, 1'b0, 32'h13, 32'd0, "ld_b_s_13");
        drain("ld_b_s_13");
        check_val("ld_b_s_13_const", resp_rdata, 32'hFFFFFF88);

        // Out-of-range word and illegal size
        issue(1'b0, 2'b11, 1'b0, 32'h1FE, 32'd0, "ld_w_1fe");
        drain("ld_w_1fe");
        check_val("ld_w_1fe_err", {31'd0, resp_err}, 32'd1);
        check_val("ld_w_1fe_rdata", resp_rdata, 32'd0);
        issue(1'b0, 2'b00, 1'b0, 32'h4, 32'd0, "size_00");
        issue(1'b0, 2'b11, 1'b0, 32'h1FC, 32'd0, "ld_w_1fc");
        drain("edge_range");

        // Misaligned word store then reload
        issue(1'b1, 2'b11, 1'b0, 32'h21, 32'h11223344, "st_w_21");
        drain("st_w_21");
`ifdef LSU_MISALIGN_SPLIT_EN
        check_val("st_w_21_err", {31'd0, resp_err}, 32'd0);
`else
        check_val("st_w_21_err", {31'd0, resp_err}, 32'd1);
        check_val("st_w_21_mem", {mem[9'h24], mem[9'h23], mem[9'h22], mem[9'h21]},
                  {init_byte(36), init_byte(35), init_byte(34), init_byte(33)});
`endif
        issue(1'b0, 2'b11, 1'b0, 32'h21, 32'd0, "ld_w_21");
        drain("ld_w_21");
`ifdef LSU_MISALIGN_SPLIT_EN
        check_val("ld_w_21_const", resp_rdata, 32'h11223344);
`endif
        issue(1'b0, 2'b10, 1'b0, 32'h23, 32'd0, "ld_h_s_23");
        drain("ld_h_s_23");

        // Reset during ACCESS of a store: no response, nothing committed
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b11; req_unsigned = 1'b0;
        req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("abort_ready", {31'd0, req_ready}, 32'd1);
        check_val("abort_valid", {31'd0, resp_valid}, 32'd0);
        check_val("abort_bus", {29'd0, MemRead, Unsigned} | {30'd0, MemWrite} | MemAddr | dataIn, 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        issue(1'b0, 2'b11, 1'b1, 32'h40, 32'd0, "ld_w_40_after_abort");
        drain("ld_w_40_after_abort");

        // Back-to-back with req_valid held high
        issue(1'b0, 2'b11, 1'b0, 32'h10, 32'd0, "b2b_0");
        n1 = accept_cyc;
        issue(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000CAFE, "b2b_1");
        n2 = accept_cyc;
        issue(1'b0, 2'b10, 1'b1, 32'h30, 32'd0, "b2b_2");
        n3 = accept_cyc;
        drain("b2b");
        check_val("b2b_spacing_01", 32'(n2 - n1), 32'd3);
        check_val("b2b_spacing_12", 32'(n3 - n2), 32'd3);

        // Randomized traffic
        for (int t = 0; t < 200; t++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)      ra = $urandom;
            else if (r == 1) ra = 32'($urandom_range(500, 511));
            else             ra = 32'($urandom_range(0, 511));
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  ra, $urandom, "rand");
            idle(int'($urandom_range(0, 2)));
        end
        drain("rand");

        // Whole memory against the reference
        bad_bytes = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad_bytes++;
        check_val("final_mem", 32'(bad_bytes), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
